// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - shared encodings for the store align unit
package store_align_unit_pkg;

    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;
    localparam logic [1:0] ST_ILL = 2'b11;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;

    localparam logic [3:0] MASK_SB = 4'b0001;
    localparam logic [3:0] MASK_SH = 4'b0011;
    localparam logic [3:0] MASK_SW = 4'b1111;

endpackage

// File: rtl/store_align_unit_st_lane_shift.sv
// rtl/store_align_unit_st_lane_shift.sv - widens store mask/data across two words
module st_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [7:0]  mask,
    output logic [63:0] wdata
);

    logic [3:0] base;

    always_comb begin
        case (sel)
            ST_SB:   base = MASK_SB;
            ST_SH:   base = MASK_SH;
            ST_SW:   base = MASK_SW;
            default: base = 4'b0000;
        endcase
    end

    // Upper half of the widened values feeds the second word of a crossing store.
    assign mask  = {4'b0000, base} << off;
    assign wdata = {32'd0, data} << {off, 3'b000};

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - splits byte/half/word stores into aligned dmem beats
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        StSel,
    output logic              dmem_valid,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_we,
    output logic [31:0]       dmem_din,
    output logic              done,
    output logic              err
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        sel_q;
    logic [1:0]        off;
    logic [7:0]        mask;
    logic [63:0]       wdata;
    logic [ADDR_W-1:0] word_addr;
    logic              crossing;
    logic              accept;

    assign off       = addr_q[1:0];
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign crossing  = ((sel_q == ST_SH) && (off == 2'd3)) ||
                       ((sel_q == ST_SW) && (off != 2'd0));

    st_lane_shift u_shift (
        .sel   (sel_q),
        .off   (off),
        .data  (data_q),
        .mask  (mask),
        .wdata (wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= ST_SB;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        data_q <= req_data;
                        sel_q  <= StSel;
                        if (StSel == ST_ILL) err <= 1'b1;
                        else state <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (dmem_ready) begin
                        if (crossing) begin
                            state <= S_BEAT1;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_BEAT1: begin
                    if (dmem_ready) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Beat outputs come straight from held registers, so they stay stable under backpressure.
    always_comb begin
        dmem_valid = 1'b0;
        dmem_addr  = '0;
        dmem_we    = 4'b0000;
        dmem_din   = 32'd0;
        case (state)
            S_BEAT0: begin
                dmem_valid = 1'b1;
                dmem_addr  = word_addr;
                dmem_we    = mask[3:0];
                dmem_din   = wdata[31:0];
            end
            S_BEAT1: begin
                dmem_valid = 1'b1;
                dmem_addr  = word_addr + ADDR_W'(4);
                dmem_we    = mask[7:4];
                dmem_din   = wdata[63:32];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - scoreboard bench for store_align_unit
module tb_store_align_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  StSel;
    logic        dmem_valid;
    logic        dmem_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic        done;
    logic        err;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t sb[$];

    logic        held_v = 1'b0;
    logic [31:0] h_addr;
    logic [3:0]  h_we;
    logic [31:0] h_din;

    store_align_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .StSel      (StSel),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_din   (dmem_din),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-by-byte reference: each byte lands at addr+i, split by word boundary.
    task automatic push_expected(input logic [1:0] sel, input logic [31:0] addr,
                                 input logic [31:0] data, output int nb);
        int    n;
        int    lane;
        beat_t b0;
        beat_t b1;
        n  = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
        b0.addr = {addr[31:2], 2'b00};
        b1.addr = b0.addr + 32'd4;
        b0.we = 4'b0; b0.din = 32'd0;
        b1.we = 4'b0; b1.din = 32'd0;
        nb = 0;
        if (sel == 2'b11) return;
        for (int i = 0; i < n; i++) begin
            lane = int'(addr[1:0]) + i;
            if (lane < 4) begin
                b0.we[lane] = 1'b1;
                b0.din[8*lane +: 8] = data[8*i +: 8];
            end else begin
                b1.we[lane-4] = 1'b1;
                b1.din[8*(lane-4) +: 8] = data[8*i +: 8];
            end
        end
        sb.push_back(b0);
        nb = 1;
        if (b1.we != 4'b0) begin
            sb.push_back(b1);
            nb = 2;
        end
    endtask

    always @(negedge clk) begin
        beat_t       e;
        logic [31:0] m;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            check("done_err_excl", done & err, 0);
            if (!dmem_valid) begin
                check("we_idle", dmem_we, 0);
                check("din_idle", dmem_din, 0);
                held_v = 1'b0;
            end else begin
                check("addr_aligned", dmem_addr[1:0], 0);
                if (held_v) begin
                    check("hold_addr", dmem_addr, h_addr);
                    check("hold_we", dmem_we, h_we);
                    check("hold_din", dmem_din, h_din);
                end
                if (dmem_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{e.we[k]}};
                        check("beat_addr", dmem_addr, e.addr);
                        check("beat_we", dmem_we, e.we);
                        check("beat_din", dmem_din & m, e.din & m);
                    end
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    h_addr = dmem_addr;
                    h_we   = dmem_we;
                    h_din  = dmem_din;
                end
            end
        end
    end

    task automatic wait_ready();
        int waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_store(input logic [1:0] sel, input logic [31:0] addr,
                            input logic [31:0] data, input int stall);
        int nb;
        wait_ready();
        push_expected(sel, addr, data, nb);
        req_valid = 1'b1; req_addr = addr; req_data = data; StSel = sel;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (sel == 2'b11) begin
            check("err_pulse", err, 1);
            check("ill_no_valid", dmem_valid, 0);
            check("ill_ready", req_ready, 1);
            check("ill_no_done", done, 0);
            @(posedge clk); #1;
            check("err_one_cycle", err, 0);
            check("ill_no_valid2", dmem_valid, 0);
        end else begin
            check("latency_valid", dmem_valid, 1);
            check("busy_not_ready", req_ready, 0);
            check("no_done_early", done, 0);
            if (stall > 0) begin
                dmem_ready = 1'b0;
                repeat (stall) @(posedge clk);
                #1;
                check("stall_valid", dmem_valid, 1);
                dmem_ready = 1'b1;
            end
            repeat (nb) @(posedge clk);
            #1;
            check("done_pulse", done, 1);
            check("idle_valid", dmem_valid, 0);
            check("idle_ready", req_ready, 1);
            check("sb_empty", sb.size(), 0);
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    task automatic reset_mid_beat1();
        beat_t b;
        wait_ready();
        b.addr = 32'h2000; b.we = 4'b1000; b.din = 32'hEF000000;
        sb.push_back(b);
        req_valid = 1'b1; req_addr = 32'h2003; req_data = 32'h0000BEEF; StSel = 2'b01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_in_beat1", dmem_addr, 32'h2004);
        rst = 1'b1;
        #1;
        check("rst_valid", dmem_valid, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_we", dmem_we, 0);
        check("rst_din", dmem_din, 0);
        check("rst_done", done, 0);
        check("rst_ready", req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", dmem_valid, 0);
            check("post_rst_done", done, 0);
        end
        check("rst_sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0;
        StSel = 2'b00; dmem_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("reset_valid", dmem_valid, 0);
        check("reset_ready", req_ready, 1);
        check("reset_addr", dmem_addr, 0);
        check("reset_we", dmem_we, 0);
        check("reset_din", dmem_din, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_store(2'b00, 32'h00001003, 32'h000000EF, 0);
        do_store(2'b01, 32'h00002003, 32'h0000BEEF, 0);
        do_store(2'b10, 32'hFFFFFFFE, 32'hDEADBEEF, 0);
        do_store(2'b10, 32'h00003000, 32'hCAFEF00D, 3);
        do_store(2'b11, 32'h00004000, 32'h12345678, 0);
        do_store(2'b01, 32'h00005001, 32'h0000A55A, 1);
        do_store(2'b10, 32'h00006003, 32'h01020304, 2);
        reset_mid_beat1();

        for (int i = 0; i < 30; i++) begin
            do_store(2'($urandom_range(0, 3)),
                     (i % 5 == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom,
                     $urandom, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
